// File: rtl/wb_multi_port_pkg.sv
// Shared constants, holding-entry layout and pointer-width helper for the
// multi-port writeback stage and its round-robin arbiter.
package wb_multi_port_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_IDX_DEF = 5;
    localparam int REG_ZERO    = 0;

    // One held writeback result at the default widths.
    typedef struct packed {
        logic                   v;
        logic                   wr;
        logic [REG_IDX_DEF-1:0] idx;
        logic [XLEN_DEF-1:0]    val;
    } hold_entry_t;

    // Width of a pointer that selects one of n sources (never narrower than 1).
    function automatic int rr_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_multi_port_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or above ptr
// (with wrap-around) wins, giving a one-hot grant plus its encoded index.
module wb_multi_port_rr_arbiter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] slot;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        slot        = '0;
        for (int k = 0; k < N; k++) begin
            slot = W'((int'(ptr) + k) % N);
            if (!grant_valid && req[slot]) begin
                grant[slot] = 1'b1;
                grant_idx   = slot;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_multi_port.sv
// Multi-source writeback stage: per-source one-entry holds drained round-robin
// onto one register-file write port. Optional macro: WB_MULTI_BYPASS_ALL_EN.
module wb_multi_port
    import wb_multi_port_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_IDX = REG_IDX_DEF,
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = rr_ptr_w(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC-1:0]         src_wr,
    input  logic [NUM_SRC*REG_IDX-1:0] src_idx,
    input  logic [NUM_SRC*XLEN-1:0]    src_val,
    input  logic                       rf_ready,
    output logic                       rf_we,
    output logic [REG_IDX-1:0]         rf_idx,
    output logic [XLEN-1:0]            rf_val,
    output logic [REG_IDX-1:0]         bp_idx,
    output logic [XLEN-1:0]            bp_val,
    output logic                       retire_valid,
    output logic [SRC_W-1:0]           retire_src
`ifdef WB_MULTI_BYPASS_ALL_EN
    ,
    output logic [NUM_SRC-1:0]         bp_all_valid,
    output logic [NUM_SRC*REG_IDX-1:0] bp_all_idx,
    output logic [NUM_SRC*XLEN-1:0]    bp_all_val
`endif
);

    logic [NUM_SRC-1:0] hold_v_p0;
    logic [NUM_SRC-1:0] hold_wr_p0;
    logic [REG_IDX-1:0] hold_idx_p0 [NUM_SRC];
    logic [XLEN-1:0]    hold_val_p0 [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] capture;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   rr_next;
    logic               gnt_vld;
    logic               gnt_wr;
    logic               gnt_we;
    logic [REG_IDX-1:0] gnt_reg;
    logic [XLEN-1:0]    gnt_val;

    // Stage p0 -> write port: arbitration over the held entries
    assign cand = (rf_ready && !flush) ? hold_v_p0 : '0;

    wb_multi_port_rr_arbiter #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_arb (
        .req         (cand),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_vld)
    );

    assign gnt_wr  = hold_wr_p0[gnt_idx];
    assign gnt_reg = hold_idx_p0[gnt_idx];
    assign gnt_val = hold_val_p0[gnt_idx];
    assign gnt_we  = gnt_vld && gnt_wr && (gnt_reg != REG_IDX'(REG_ZERO));

    assign rf_we        = gnt_we;
    assign rf_idx       = gnt_vld ? gnt_reg : '0;
    assign rf_val       = gnt_vld ? gnt_val : '0;
    assign bp_idx       = gnt_we ? gnt_reg : '0;
    assign bp_val       = gnt_we ? gnt_val : '0;
    assign retire_valid = gnt_vld;
    assign retire_src   = gnt_vld ? gnt_idx : '0;

    assign rr_next = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // A granted hold frees up this cycle, so it can be refilled immediately.
    assign src_ready = flush ? '0 : (~hold_v_p0 | grant);
    assign capture   = src_valid & src_ready;

    // Source -> stage p0: holding-register control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_p0 <= '0;
            rr_ptr    <= '0;
        end else begin
            if (flush) begin
                hold_v_p0 <= '0;
            end else begin
                hold_v_p0 <= capture | (hold_v_p0 & ~grant);
            end
            if (gnt_vld) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Source -> stage p0: holding-register payload
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i]) begin
                hold_wr_p0[i]  <= src_wr[i];
                hold_idx_p0[i] <= src_idx[i*REG_IDX +: REG_IDX];
                hold_val_p0[i] <= src_val[i*XLEN +: XLEN];
            end
        end
    end

`ifdef WB_MULTI_BYPASS_ALL_EN
    // Every pending write is forwarded, not just the one granted this cycle.
    always_comb begin
        bp_all_valid = '0;
        bp_all_idx   = '0;
        bp_all_val   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bp_all_valid[i] = !flush && hold_v_p0[i] && hold_wr_p0[i] &&
                              (hold_idx_p0[i] != REG_IDX'(REG_ZERO));
            bp_all_idx[i*REG_IDX +: REG_IDX] = bp_all_valid[i] ? hold_idx_p0[i] : '0;
            bp_all_val[i*XLEN +: XLEN]       = bp_all_valid[i] ? hold_val_p0[i] : '0;
        end
    end
`endif

endmodule

// File: doc/wb_multi_port.md
Name: wb_multi_port

Overview:
- Parametrised successor to the single-channel writeback stage.
- Accepts NUM_SRC independent writeback channels (ALU, LSU, MUL, ...), each behind its own one-entry holding register with a valid/ready handshake.
- Round-robin arbitration drains the held entries onto one register-file write port, and the granted entry is driven onto a bypass bus.
- Supports a pipeline flush and a write-port stall; sits between the execute units and the register file.

Parameters:
- XLEN, 32, data width.
- REG_IDX, 5, register index width.
- NUM_SRC, 3, number of writeback source channels (2..8).
- SRC_W, $clog2(NUM_SRC), width of the source id and round-robin pointer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all held entries.
- src_valid  in  NUM_SRC  per-source request valid.
- src_ready  out  NUM_SRC  per-source ready.
- src_wr  in  NUM_SRC  per-source "instruction writes rd" flag.
- src_idx  in  NUM_SRC*REG_IDX  per-source destination index, flattened, source 0 in LSBs.
- src_val  in  NUM_SRC*XLEN  per-source result, flattened.
- rf_ready  in  1  write port available this cycle.
- rf_we  out  1  register-file write enable.
- rf_idx  out  REG_IDX  register-file write index.
- rf_val  out  XLEN  register-file write data.
- bp_idx  out  REG_IDX  bypass index; 0 means no bypass.
- bp_val  out  XLEN  bypass data; 0 when bp_idx is 0.
- retire_valid  out  1  one entry drained this cycle.
- retire_src  out  SRC_W  source id of the drained entry.

Behaviour:
- Reset: asynchronous, active-low.
  - hold_v[*]=0, rr_ptr=0.
  - After reset, outputs are rf_we=0, rf_idx=0, rf_val=0, bp_*=0, retire_valid=0, retire_src=0, src_ready=all-1.
  - Assertion mid-operation drops every held entry immediately; no write occurs.
- Per-source holding register fields: hold_v, hold_wr, hold_idx, hold_val.
  - Capture at posedge when src_valid[i] & src_ready[i] & ~flush.
- src_ready[i] = ~flush & (~hold_v[i] | grant[i]).
  - A granted entry may be replaced in the same cycle, giving a throughput of 1 per source per cycle.
- Arbitration (combinational):
  - Candidates are hold_v[i] when rf_ready=1 and flush=0; otherwise there are none.
  - Grant goes to the first candidate searching from rr_ptr upward with wrap-around.
  - At most one grant per cycle.
- rr_ptr update: on a grant to source g, rr_ptr <= (g+1) mod NUM_SRC; otherwise it is unchanged.
- Drain: the granted entry clears its hold_v at posedge unless it is re-captured that cycle.
  - retire_valid=1 and retire_src=g, even when hold_wr=0 or hold_idx=0.
- Write: rf_we = grant & hold_wr[g] & (hold_idx[g]!=0).
  - rf_idx/rf_val carry the granted entry when a grant exists; otherwise they are 0.
- Bypass: bp_idx/bp_val equal rf_idx/rf_val when rf_we=1; otherwise both are 0.
- Latency: an entry captured at edge t is written at the earliest in the cycle after t, i.e. rf_we is high during [t, t+1).
- Worst-case wait is NUM_SRC-1 cycles while rf_ready stays high.
- rf_ready=0: no grant, no drain, no retire.
  - Sources whose holds are full see src_ready=0; empty holds still accept.
- flush=1: no grant, no write, no capture, src_ready=0.
  - All hold_v cleared at posedge; rr_ptr is unchanged.
- Simultaneous capture and drain on the same source: the new data replaces the drained data, and hold_v stays 1.

Optional Feature:
- Macro WB_MULTI_BYPASS_ALL_EN.
- When defined, adds three ports:
  - bp_all_valid out NUM_SRC = hold_v & hold_wr & (hold_idx!=0), masked by ~flush.
  - bp_all_idx out NUM_SRC*REG_IDX.
  - bp_all_val out NUM_SRC*XLEN.
- These expose every pending result to the decode-stage forwarding network, not just the granted one; gated-off entries drive 0.
- When undefined, the ports are absent and only bp_idx/bp_val exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - XLEN and REG_IDX defaults.
  - The register-zero constant.
  - The holding-entry struct {v, wr, idx, val}.
  - The rr-pointer width function.
- One natural sub-module, rr_arbiter: NUM_SRC requests plus a pointer in, one-hot grant and encoded index out; purely combinational, so it is reusable for the issue logic.

Test Plan:
- Single source: src0 writes idx=5, val=0xDEAD_BEEF with rf_ready=1 → next cycle rf_we=1, rf_idx=5, rf_val=0xDEADBEEF, bp_idx=5, retire_src=0.
- Three sources valid together (idx 1, 2, 3), rr_ptr=0 → writes in order src0, src1, src2 on three consecutive cycles; rr_ptr ends at 0.
- idx=0 or src_wr=0 on src1 → retire_valid=1, retire_src=1, rf_we=0, bp_idx=0, bp_val=0.
- rf_ready held 0 for 4 cycles with src0 full → src_ready[0]=0 and no retire; src2 is still accepted while empty; after rf_ready=1, drains resume in rr order.
- flush asserted while src0 and src2 are held → no write that cycle; both holds cleared; a capture attempted in the same cycle is dropped.
- rst_n pulsed low mid-stream → outputs zero immediately with no clock edge; src_ready=all-1 after release; a drain requested before the reset never appears.
